// File: rtl/data_memory_unit.sv
// Data-memory responder: self-clears its RAM after reset, then serves CPU
// writes every cycle and reads with a fixed latency on the shared data bus.
module data_memory_unit #(
   parameter int         ADDR_W    = 8,
   parameter int         DATA_W    = 8,
   parameter int         READ_LAT  = 1,
   parameter logic [7:0] CMD_NOP   = 8'h00,
   parameter logic [7:0] CMD_READ  = 8'h01,
   parameter logic [7:0] CMD_WRITE = 8'h02
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        cmd_memory,
   input  logic [ADDR_W-1:0] addr_memory,
   inout  wire  [DATA_W-1:0] data_memory,
   output logic              ready,
   output logic              cmd_err
);

   localparam int         DEPTH     = 1 << ADDR_W;
   localparam logic [3:0] WAIT_INIT = 4'(READ_LAT - 1);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_RWAIT, S_RDRIVE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_q, clr_d;
   logic [3:0]          wait_q, wait_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   rdata_q;
   logic                oe_q, oe_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                cap_en;
   logic [ADDR_W-1:0]   cap_addr;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   // State register and control flops
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         clr_q   <= '0;
         wait_q  <= '0;
         oe_q    <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         wait_q  <= wait_d;
         oe_q    <= oe_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:   if (clr_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
         S_IDLE:   if (cmd_memory == CMD_READ)
                      state_d = (READ_LAT == 1) ? S_RDRIVE : S_RWAIT;
         S_RWAIT:  if (wait_q == 4'd1) state_d = S_RDRIVE;
         S_RDRIVE: state_d = S_IDLE;
         default:  state_d = S_INIT;
      endcase
   end

   always_comb begin
      clr_d     = clr_q;
      wait_d    = wait_q;
      addr_d    = addr_q;
      err_d     = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = addr_memory;
      mem_wdata = data_memory;
      cap_en    = 1'b0;
      cap_addr  = addr_q;
      case (state_q)
         S_INIT: begin
            mem_we    = 1'b1;
            mem_waddr = clr_q;
            mem_wdata = '0;
            clr_d     = clr_q + 1'b1;
         end
         S_IDLE: begin
            case (cmd_memory)
               CMD_NOP:   ;
               CMD_WRITE: mem_we = 1'b1;
               CMD_READ: begin
                  addr_d = addr_memory;
                  wait_d = WAIT_INIT;
                  if (READ_LAT == 1) begin
                     cap_en   = 1'b1;
                     cap_addr = addr_memory;
                  end
               end
               default:   err_d = 1'b1;
            endcase
         end
         S_RWAIT: begin
            wait_d = wait_q - 4'd1;
            if (wait_q == 4'd1) cap_en = 1'b1;
         end
         default: ;
      endcase
      oe_d    = (state_d == S_RDRIVE);
      ready_d = (state_d == S_IDLE);
   end

   // Storage and read capture carry no reset; writes are blocked while in reset
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      if (cap_en) rdata_q <= mem_q[cap_addr];
      if (mem_we && rst_n) mem_q[mem_waddr] <= mem_wdata;
   end

   assign data_memory = oe_q ? rdata_q : {DATA_W{1'bz}};
   assign ready       = ready_q;
   assign cmd_err     = err_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: three instances (READ_LAT 1, 3, 4) share the
// command stream; a per-instance transaction model predicts every cycle.
module tb_data_memory_unit;

   localparam int         NI    = 3;
   localparam logic [7:0] C_NOP = 8'h00;
   localparam logic [7:0] C_RD  = 8'h01;
   localparam logic [7:0] C_WR  = 8'h02;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    cmd, addr, tb_dat;
   logic [NI-1:0] tb_oe;
   logic [NI-1:0] rdy, err;
   wire  [7:0]    bus0, bus1, bus2;

   always #5 clk = ~clk;

   assign bus0 = tb_oe[0] ? tb_dat : 8'bz;
   assign bus1 = tb_oe[1] ? tb_dat : 8'bz;
   assign bus2 = tb_oe[2] ? tb_dat : 8'bz;

   data_memory_unit #(.READ_LAT(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .cmd_memory(cmd), .addr_memory(addr),
      .data_memory(bus0), .ready(rdy[0]), .cmd_err(err[0]));
   data_memory_unit #(.READ_LAT(3)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .cmd_memory(cmd), .addr_memory(addr),
      .data_memory(bus1), .ready(rdy[1]), .cmd_err(err[1]));
   data_memory_unit #(.READ_LAT(4)) u_lat4 (
      .clk(clk), .rst_n(rst_n), .cmd_memory(cmd), .addr_memory(addr),
      .data_memory(bus2), .ready(rdy[2]), .cmd_err(err[2]));

   // Transaction-level model: memory contents, pending read and its timing
   logic [7:0] mem_m [NI][256];
   int         init_m  [NI];
   bit         rdy_m   [NI];
   bit         err_m   [NI];
   bit         drv_m   [NI];
   bit         pend_m  [NI];
   int         drv_at  [NI];
   int         free_at [NI];
   logic [7:0] val_m   [NI];
   int         k;
   int         n_cmp = 0;
   int         n_bad = 0;

   function automatic int lat_of(int i);
      return (i == 0) ? 1 : (i == 1) ? 3 : 4;
   endfunction

   function automatic logic [7:0] bus_of(int i);
      case (i)
         0:       return bus0;
         1:       return bus1;
         default: return bus2;
      endcase
   endfunction

   task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s[lat%0d] edge %0d: got %0h expected %0h", tag, lat_of(idx), k, got, exp);
      end
   endtask

   task automatic model_edge(input int i);
      if (!rst_n) begin
         init_m[i] = 0;
         pend_m[i] = 1'b0;
         rdy_m[i]  = 1'b0;
         err_m[i]  = 1'b0;
         drv_m[i]  = 1'b0;
         for (int j = 0; j < 256; j++) mem_m[i][j] = 8'h00;
      end else begin
         err_m[i] = 1'b0;
         if (rdy_m[i]) begin
            if (cmd == C_WR) mem_m[i][addr] = tb_dat;
            else if (cmd == C_RD) begin
               pend_m[i]  = 1'b1;
               val_m[i]   = mem_m[i][addr];
               drv_at[i]  = k + lat_of(i) - 1;
               free_at[i] = k + lat_of(i);
            end else if (cmd != C_NOP) err_m[i] = 1'b1;
         end
         if (init_m[i] < 256) init_m[i]++;
         drv_m[i] = pend_m[i] && (k == drv_at[i]);
         if (pend_m[i] && k >= free_at[i]) pend_m[i] = 1'b0;
         rdy_m[i] = (init_m[i] >= 256) && !pend_m[i];
      end
   endtask

   task automatic compare(input int i);
      logic [7:0] b;
      b = bus_of(i);
      chk("ready", i, 32'(rdy[i]), 32'(rdy_m[i]));
      chk("cmd_err", i, 32'(err[i]), 32'(err_m[i]));
      if (drv_m[i]) chk("bus_data", i, 32'(b), 32'(val_m[i]));
      else          chk("bus_idle", i, 32'($isunknown(b) || b == 8'h00), 32'd1);
   endtask

   task automatic step(input logic r, input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
      rst_n  = r;
      cmd    = c;
      addr   = a;
      tb_dat = d;
      for (int i = 0; i < NI; i++) tb_oe[i] = (c == C_WR) && !drv_m[i];
      @(posedge clk);
      k++;
      for (int i = 0; i < NI; i++) model_edge(i);
      #1 tb_oe = '0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) compare(i);
   endtask

   task automatic nop(input int n);
      repeat (n) step(1'b1, C_NOP, 8'h00, 8'h00);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      step(1'b1, C_WR, a, d);
   endtask

   task automatic rd(input logic [7:0] a);
      step(1'b1, C_RD, a, 8'h00);
   endtask

   initial begin
      logic [7:0] rc, ra;
      int         sel;
      rst_n = 1'b0; cmd = C_NOP; addr = '0; tb_dat = '0; tb_oe = '0; k = 0;

      // Reset, then INIT lasting 256 cycles while READ is held
      repeat (3) step(1'b0, C_RD, 8'h10, 8'h00);
      for (int n = 0; n < 256; n++) begin
         step(1'b1, C_RD, 8'h10, 8'h00);
         if (n == 254) chk("init_still_busy", 0, 32'(rdy[0]), 32'd0);
         if (n == 255) chk("init_done", 2, 32'(rdy[2]), 32'd1);
      end
      rd(8'h10); nop(5);

      // Read-after-write
      wr(8'h3C, 8'hA5); rd(8'h3C); nop(5);

      // Commands during a read are dropped
      wr(8'h07, 8'h5A); wr(8'h20, 8'h11); wr(8'h21, 8'h22);
      rd(8'h07); wr(8'h20, 8'hFF); nop(1); wr(8'h20, 8'hEE); wr(8'h21, 8'h77);
      nop(5); rd(8'h20); nop(5); rd(8'h21); nop(5);

      // Full-array write then readback
      for (int a = 0; a < 256; a++) wr(8'(a), ~8'(a));
      for (int a = 0; a < 256; a++) begin rd(8'(a)); nop(5); end

      // Undefined codes when idle and when busy
      nop(2); step(1'b1, 8'h03, 8'h55, 8'h00); nop(1); step(1'b1, 8'hFF, 8'h56, 8'h00);
      nop(2); rd(8'h55); nop(5); rd(8'h56); nop(5);
      rd(8'h3C); step(1'b1, 8'h03, 8'h3C, 8'h00); step(1'b1, 8'hFF, 8'h3C, 8'h00); nop(5);

      // Randomized traffic on a small address window to force collisions
      repeat (1500) begin
         sel = int'($urandom_range(0, 9));
         ra  = 8'($urandom_range(0, 15));
         if (sel < 4)       rc = C_WR;
         else if (sel < 7)  rc = C_RD;
         else if (sel == 7) rc = C_NOP;
         else               rc = 8'($urandom_range(0, 255));
         step(1'b1, rc, ra, 8'($urandom));
      end
      nop(6);

      // Reset while reads are still waiting, then INIT again
      wr(8'h40, 8'hC3); nop(2); rd(8'h40); nop(1);
      step(1'b0, C_NOP, 8'h00, 8'h00); step(1'b0, C_NOP, 8'h00, 8'h00);
      nop(258);
      rd(8'h40); nop(5); rd(8'h3C); nop(5); rd(8'h07); nop(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
